// File: rtl/ps2_rx_frame_if.sv
// PS/2 receiver port bundle: raw PS/2 lines in, decoded byte and status strobes out.
// Combinational wiring only; the receiver has no backpressure.
interface ps2_rx_frame_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       keyPressed;
    logic       frame_err;
    logic       busy;

    modport master (
        output ps2_clk, ps2_data,
        input  scancode, keyPressed, frame_err, busy
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output scancode, keyPressed, frame_err, busy
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: oversampled, filtered 11-bit frames -> scancode + keyPressed; `PS2_BREAK_FILTER_EN hides F0 break codes.
// Latency: keyPressed/frame_err 1 clk after the stop-bit fall (2-FF sync + FILTER_LEN filter ahead of that).
// Backpressure: none; each strobe is one cycle and scancode holds until the next valid byte.
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic          clk,
    input  logic          rstn,
    ps2_rx_frame_if.slave ps2
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic [FW-1:0] flt_cnt;
    logic          clk_f, clk_f_q, fall;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    sc_q, sc_d;
    logic          kp_q, kp_d;
    logic          err_q, err_d;
    logic          busy_q;
    logic          brk_q, brk_d;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];
    assign fall  = clk_f_q & ~clk_f;

    // Lines idle high, so synchronisers and filter reset to 1 to avoid a false start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            flt_cnt  <= '0;
            clk_f    <= 1'b1;
            clk_f_q  <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2.ps2_clk};
            dat_sync <= {dat_sync[0], ps2.ps2_data};
            clk_f_q  <= clk_f;
            if (clk_s == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_f   <= clk_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            to_q      <= '0;
            sc_q      <= 8'h00;
            kp_q      <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            to_q      <= to_d;
            sc_q      <= sc_d;
            kp_q      <= kp_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
            brk_q     <= brk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        to_d      = to_q;
        sc_d      = sc_q;
        kp_d      = 1'b0;
        err_d     = 1'b0;
        brk_d     = brk_q;

        case (state_q)
            IDLE: begin
                if (fall && !dat_s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_d[bit_cnt_q] = dat_s;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (dat_s && (^{shreg_q, par_q})) begin
`ifdef PS2_BREAK_FILTER_EN
                        // F0 arms the flag; the byte after it is the released key and is swallowed too.
                        if (brk_q) begin
                            brk_d = 1'b0;
                        end else if (shreg_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            sc_d = shreg_q;
                            kp_d = 1'b1;
                        end
`else
                        sc_d = shreg_q;
                        kp_d = 1'b1;
`endif
                    end else begin
                        err_d = 1'b1;
                        brk_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fall on the limit cycle wins: counter clears and the frame carries on.
        if (state_q == IDLE) begin
            to_d = '0;
        end else if (fall) begin
            to_d = '0;
        end else if (to_q == TO_LAST) begin
            state_d = IDLE;
            to_d    = '0;
            err_d   = 1'b1;
            brk_d   = 1'b0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + TW'(1);
        end
    end

    assign ps2.scancode   = sc_q;
    assign ps2.keyPressed = kp_q;
    assign ps2.frame_err  = err_q;
    assign ps2.busy       = busy_q;
endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame with a shortened PS/2 bit period and timeout.
module tb_ps2_rx_frame;
    localparam int FLT = 8;
    localparam int TO  = 200;
    localparam int H   = 20;          // PS/2 clock half-period in clk cycles
    localparam int LAT = 2 + FLT + 1; // raw fall -> strobe: sync, filter, register

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ps2_rx_frame_if ifc ();
    ps2_rx_frame #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .ps2  (ifc.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int kp_cnt = 0, err_cnt = 0, both_cnt = 0;
    int last_evt = 0, fall_cyc = 0;
    bit busy_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifc.keyPressed) begin kp_cnt++;  last_evt = cyc; end
        if (ifc.frame_err)  begin err_cnt++; last_evt = cyc; end
        if (ifc.keyPressed && ifc.frame_err) both_cnt++;
        if (ifc.busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ifc.ps2_data = b;
        wait_cyc(H);
        ifc.ps2_clk = 1'b0;
        fall_cyc = cyc;
        wait_cyc(H);
        ifc.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        wait_cyc(H);
        ifc.ps2_data = 1'b1;
    endtask

    int kp0, er0;

    initial begin
        ifc.ps2_clk  = 1'b1;
        ifc.ps2_data = 1'b1;
        wait_cyc(3);
        #1;
        check("rst_scancode", {24'd0, ifc.scancode}, 32'h00);
        check("rst_kp",       {31'd0, ifc.keyPressed}, 32'd0);
        check("rst_err",      {31'd0, ifc.frame_err}, 32'd0);
        check("rst_busy",     {31'd0, ifc.busy}, 32'd0);
        rstn = 1'b1;
        wait_cyc(20);

        // 1: good 8'h1C frame
        kp0 = kp_cnt; er0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t1_kp_cnt",   kp_cnt - kp0, 1);
        check("t1_err_cnt",  err_cnt - er0, 0);
        check("t1_scancode", {24'd0, ifc.scancode}, 32'h1C);
        check("t1_latency",  last_evt - fall_cyc, LAT);
        check("t1_busy",     {31'd0, ifc.busy}, 32'd0);

        // 4: start + 4 data bits, then the clock stops
        wait_cyc(40);
        er0 = err_cnt; kp0 = kp_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ifc.ps2_data = 1'b1;
        for (int i = 0; i < TO + 50 && err_cnt == er0; i++) wait_cyc(1);
        check("t4_err_cnt", err_cnt - er0, 1);
        check("t4_to_lat",  last_evt - fall_cyc, LAT + TO);
        check("t4_kp_cnt",  kp_cnt - kp0, 0);
        wait_cyc(2);
        check("t4_busy",    {31'd0, ifc.busy}, 32'd0);
        wait_cyc(20);
        kp0 = kp_cnt;
        send_frame(8'h32, 1'b0, 1'b1);
        check("t4_kp_32",   kp_cnt - kp0, 1);
        check("t4_sc_32",   {24'd0, ifc.scancode}, 32'h32);

        // 2: parity error keeps the previous byte
        wait_cyc(40);
        kp0 = kp_cnt; er0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        check("t2_err_cnt", err_cnt - er0, 1);
        check("t2_kp_cnt",  kp_cnt - kp0, 0);
        check("t2_latency", last_evt - fall_cyc, LAT);
        check("t2_scancode", {24'd0, ifc.scancode}, 32'h32);

        // stop-bit error
        wait_cyc(40);
        kp0 = kp_cnt; er0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b0);
        check("stop_err_cnt", err_cnt - er0, 1);
        check("stop_kp_cnt",  kp_cnt - kp0, 0);
        check("stop_sc",      {24'd0, ifc.scancode}, 32'h32);

        // 3: short low glitches on idle ps2_clk with data low
        wait_cyc(40);
        kp0 = kp_cnt; er0 = err_cnt;
        busy_seen = 1'b0;
        ifc.ps2_data = 1'b0;
        ifc.ps2_clk = 1'b0; wait_cyc(3);     ifc.ps2_clk = 1'b1; wait_cyc(30);
        ifc.ps2_clk = 1'b0; wait_cyc(FLT - 1); ifc.ps2_clk = 1'b1; wait_cyc(30);
        ifc.ps2_data = 1'b1;
        check("t3_busy_seen", {31'd0, busy_seen}, 32'd0);
        check("t3_pulses",    (kp_cnt - kp0) + (err_cnt - er0), 0);

        // 5: break sequence F0 1C
        wait_cyc(20);
        kp0 = kp_cnt;
        send_frame(8'hF0, 1'b1, 1'b1);
`ifdef PS2_BREAK_FILTER_EN
        check("t5_sc_after_f0", {24'd0, ifc.scancode}, 32'h32);
`else
        check("t5_sc_after_f0", {24'd0, ifc.scancode}, 32'hF0);
`endif
        wait_cyc(40);
        send_frame(8'h1C, 1'b0, 1'b1);
`ifdef PS2_BREAK_FILTER_EN
        check("t5_kp_cnt",     kp_cnt - kp0, 0);
        check("t5_sc_after_1c", {24'd0, ifc.scancode}, 32'h32);
`else
        check("t5_kp_cnt",     kp_cnt - kp0, 2);
        check("t5_sc_after_1c", {24'd0, ifc.scancode}, 32'h1C);
`endif

        // 6: reset after bit 5 of a frame
        wait_cyc(40);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rstn = 1'b0;
        #1;
        check("t6_rst_sc",   {24'd0, ifc.scancode}, 32'h00);
        check("t6_rst_busy", {31'd0, ifc.busy}, 32'd0);
        check("t6_rst_kp",   {31'd0, ifc.keyPressed}, 32'd0);
        check("t6_rst_err",  {31'd0, ifc.frame_err}, 32'd0);
        wait_cyc(4);
        rstn = 1'b1;
        wait_cyc(30);
        kp0 = kp_cnt; er0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t6_kp_cnt",   kp_cnt - kp0, 1);
        check("t6_err_cnt",  err_cnt - er0, 0);
        check("t6_scancode", {24'd0, ifc.scancode}, 32'h1C);

        check("never_both", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
